// File: rtl/noc_pkg.sv
// Shared constants, field helpers and occupancy-state encoding for the
// network4x4 ejection receiver.
package noc_pkg;

  localparam int PACKET_SIZE = 16;
  localparam int HDR_W       = 4;

  localparam logic [HDR_W-1:0] NULL_TAG = '0;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_NONEMPTY = 2'd1,
    ST_FULL     = 2'd2
  } fifo_state_e;

  function automatic logic [HDR_W-1:0] get_tag(input logic [PACKET_SIZE-1:0] pkt);
    return pkt[PACKET_SIZE-1 -: HDR_W];
  endfunction

  function automatic logic [PACKET_SIZE-HDR_W-1:0] get_payload(input logic [PACKET_SIZE-1:0] pkt);
    return pkt[PACKET_SIZE-HDR_W-1:0];
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word and a three-state
// occupancy FSM (EMPTY / NONEMPTY / FULL) driving valid and full.
module noc_sync_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  fifo_state_e      r_state;
  fifo_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_dout_nxt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_state != ST_FULL);
  assign w_pop   = i_pop  && (r_state != ST_EMPTY);
  assign o_valid = (r_state != ST_EMPTY);
  assign o_full  = (r_state == ST_FULL);
  assign o_dout  = r_dout;

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_rd_ptr_nxt = r_rd_ptr;
    w_dout_nxt   = '0;

    if (w_pop) w_rd_ptr_nxt = r_rd_ptr + 1'b1;

    if (w_push && !w_pop)      w_count_nxt = r_count + ONE_C;
    else if (w_pop && !w_push) w_count_nxt = r_count - ONE_C;

    case (r_state)
      ST_EMPTY:    if (w_push) w_state_nxt = ST_NONEMPTY;
      ST_NONEMPTY: begin
        if (w_push && !w_pop && (r_count == DEPTH_C - ONE_C))  w_state_nxt = ST_FULL;
        else if (w_pop && !w_push && (r_count == ONE_C))       w_state_nxt = ST_EMPTY;
      end
      ST_FULL:     if (w_pop) w_state_nxt = ST_NONEMPTY;
      default:     w_state_nxt = ST_EMPTY;
    endcase

    // The new head is the word being written this cycle when the read pointer
    // lands on the write slot; otherwise it already sits in memory.
    if (w_count_nxt == '0)                      w_dout_nxt = '0;
    else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) w_dout_nxt = i_din;
    else                                        w_dout_nxt = r_mem[w_rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state  <= ST_EMPTY;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_dout   <= w_dout_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_reset) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/noc_eject_rx.sv
// Ejection-port receiver: drops null (tag 0) packets, queues the rest and
// splits the head into tag and payload. NOC_EJECT_STATS_EN adds packet counters.
module noc_eject_rx #(
  parameter int packet_size = 16,
  parameter int HDR_W       = 4,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic [packet_size-1:0]   i_pkt,
  input  logic                     i_pkt_valid,
  output logic                     o_rd_en,
  output logic [HDR_W-1:0]         o_tag,
  output logic [packet_size-HDR_W-1:0] o_data,
  output logic                     o_data_valid,
  input  logic                     i_rd_en,
`ifdef NOC_EJECT_STATS_EN
  output logic [15:0]              o_pkt_cnt,
  output logic [15:0]              o_null_cnt,
`endif
  output logic                     o_full
);

  logic [HDR_W-1:0]       w_tag_in;
  logic                   w_take;
  logic                   w_store;
  logic                   w_full;
  logic [packet_size-1:0] w_head;

  assign w_tag_in = i_pkt[packet_size-1 -: HDR_W];
  assign o_rd_en  = !w_full;
  assign o_full   = w_full;
  assign w_take   = i_pkt_valid && o_rd_en;
  assign w_store  = w_take && (w_tag_in != HDR_W'(noc_pkg::NULL_TAG));

  noc_sync_fifo #(
    .WIDTH (packet_size),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_reset (i_reset),
    .i_push  (w_store),
    .i_din   (i_pkt),
    .i_pop   (i_rd_en),
    .o_dout  (w_head),
    .o_valid (o_data_valid),
    .o_full  (w_full)
  );

  assign o_tag  = w_head[packet_size-1 -: HDR_W];
  assign o_data = w_head[packet_size-HDR_W-1:0];

`ifdef NOC_EJECT_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_null_cnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_pkt_cnt  <= '0;
      r_null_cnt <= '0;
    end else begin
      if (w_store && (r_pkt_cnt != 16'hFFFF)) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_take && !w_store && (r_null_cnt != 16'hFFFF)) r_null_cnt <= r_null_cnt + 16'd1;
    end
  end

  assign o_pkt_cnt  = r_pkt_cnt;
  assign o_null_cnt = r_null_cnt;
`endif

endmodule

// File: tb/tb_noc_eject_rx.sv
// Scoreboard bench for noc_eject_rx: stored packets are queued as expected
// head words and a monitor compares them whenever the consumer pops.
module tb_noc_eject_rx;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_pkt;
  logic        i_pkt_valid;
  logic        o_rd_en;
  logic [3:0]  o_tag;
  logic [11:0] o_data;
  logic        o_data_valid;
  logic        i_rd_en;
  logic        o_full;
`ifdef NOC_EJECT_STATS_EN
  logic [15:0] o_pkt_cnt;
  logic [15:0] o_null_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  noc_eject_rx dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_pkt        (i_pkt),
    .i_pkt_valid  (i_pkt_valid),
    .o_rd_en      (o_rd_en),
    .o_tag        (o_tag),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_rd_en      (i_rd_en),
`ifdef NOC_EJECT_STATS_EN
    .o_pkt_cnt    (o_pkt_cnt),
    .o_null_cnt   (o_null_cnt),
`endif
    .o_full       (o_full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] p, input bit stored);
    i_pkt       = p;
    i_pkt_valid = 1'b1;
    if (stored) exp_q.push_back(p);
    tick();
    i_pkt_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: every accepted pop must present the oldest expected packet.
  initial begin
    forever begin
      @(negedge clk);
      if (!i_reset && o_data_valid && i_rd_en) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", {16'h0, o_tag, o_data}, 32'hDEAD);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("pop_head", {16'h0, o_tag, o_data}, {16'h0, e});
        end
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_pkt = '0; i_pkt_valid = 1'b0; i_rd_en = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_rd_en",  o_rd_en, 1);
    check("rst_valid",  o_data_valid, 0);
    check("rst_full",   o_full, 0);
    check("rst_tag",    o_tag, 0);
    check("rst_data",   o_data, 0);

    // Single packet, held until the consumer reads it
    tick();
    send(16'h107F, 1);
    @(negedge clk);
    check("one_valid", o_data_valid, 1);
    check("one_tag",   o_tag, 4'h1);
    check("one_data",  o_data, 12'h07F);
    tick(); tick();
    @(negedge clk);
    check("one_hold_valid", o_data_valid, 1);
    check("one_hold_data",  o_data, 12'h07F);
    tick();
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    @(negedge clk);
    check("one_empty_valid", o_data_valid, 0);
    check("one_empty_tag",   o_tag, 0);

    // Null filter
    do_reset();
    send(16'h0ABC, 0);
    send(16'h20FE, 1);
    @(negedge clk);
    check("null_valid", o_data_valid, 1);
    check("null_tag",   o_tag, 4'h2);
    check("null_data",  o_data, 12'h0FE);
`ifdef NOC_EJECT_STATS_EN
    check("null_cnt", o_null_cnt, 1);
    check("pkt_cnt",  o_pkt_cnt, 1);
`endif
    tick();
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    @(negedge clk);
    check("null_drained", o_data_valid, 0);

    // Fill to capacity, reject a ninth packet, then drain in order
    tick();
    for (int k = 1; k <= 8; k++) send(16'h3000 + 16'(k), 1);
    @(negedge clk);
    check("fill_full",  o_full, 1);
    check("fill_rd_en", o_rd_en, 0);
    check("fill_head",  o_data, 12'h001);
    tick();
    send(16'h3009, 0);
    i_rd_en = 1'b1;
    @(negedge clk);
    check("pop_cycle_rd_en", o_rd_en, 0);
    tick();
    i_rd_en = 1'b0;
    @(negedge clk);
    check("after_pop_rd_en", o_rd_en, 1);
    check("after_pop_full",  o_full, 0);
    check("after_pop_head",  o_data, 12'h002);
    tick();
    i_rd_en = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    i_rd_en = 1'b0;
    @(negedge clk);
    check("fill_drained", o_data_valid, 0);
    check("fill_queue",   exp_q.size(), 0);

    // Steady push+pop at occupancy 3 across pointer wrap
    tick();
    for (int k = 0; k < 3; k++) send(16'h4000 + 16'(k), 1);
    i_rd_en = 1'b1;
    for (int k = 0; k < 20; k++) send(16'h5000 + 16'(k), 1);
    i_rd_en = 1'b0;
    @(negedge clk);
    check("stream_valid", o_data_valid, 1);
    check("stream_full",  o_full, 0);
    check("stream_head",  {o_tag, o_data}, 16'h5011);
    tick();
    i_rd_en = 1'b1;
    tick(); tick(); tick();
    i_rd_en = 1'b0;
    @(negedge clk);
    check("stream_count3", o_data_valid, 0);
    check("stream_queue",  exp_q.size(), 0);

    // Reset with 5 stored plus a concurrent push and pop
    tick();
    for (int k = 0; k < 5; k++) send(16'h6000 + 16'(k), 1);
    i_pkt       = 16'h7123;
    i_pkt_valid = 1'b1;
    i_rd_en     = 1'b1;
    i_reset     = 1'b1;
    tick();
    i_pkt_valid = 1'b0;
    i_rd_en     = 1'b0;
    i_reset     = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst2_valid", o_data_valid, 0);
    check("rst2_full",  o_full, 0);
    check("rst2_rd_en", o_rd_en, 1);
    check("rst2_tag",   o_tag, 0);
    check("rst2_data",  o_data, 0);
`ifdef NOC_EJECT_STATS_EN
    check("rst2_pkt_cnt",  o_pkt_cnt, 0);
    check("rst2_null_cnt", o_null_cnt, 0);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/noc_eject_rx.md
Name: noc_eject_rx

Overview:
- Receive side of the network4x4 ejection port. Consumes packets presented on the network's o_DATA and throttles the network through its i_rd_en.
- Discards null (all-header-zero) packets, buffers valid packets in a FIFO, and splits each into header tag and payload.
- Presents tag and payload to a downstream consumer (neuron layer / host sink) with a valid/read handshake.
- Sits between network4x4 and the next compute stage; it is the counterpart of the injection stimulus path.

Parameters:
- packet_size, 16, packet width in bits (matches network4x4).
- HDR_W, 4, header tag width taken from the packet MSBs.
- DEPTH, 8, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  synchronous active-high reset.
- i_pkt  input  packet_size  packet from network o_DATA.
- i_pkt_valid  input  1  i_pkt holds a packet this cycle.
- o_rd_en  output  1  ready to network; drives network4x4 i_rd_en.
- o_tag  output  HDR_W  head packet tag, i_pkt[packet_size-1 -: HDR_W].
- o_data  output  packet_size-HDR_W  head packet payload, low bits.
- o_data_valid  output  1  FIFO head valid (show-ahead).
- i_rd_en  input  1  consumer pops head when o_data_valid is high.
- o_full  output  1  FIFO count equals DEPTH.

Behaviour:
- Reset: one clock and synchronous active-high reset (i_reset); no other reset exists.
  - On i_reset high at a rising edge: FIFO emptied (rd_ptr=wr_ptr=0, count=0); o_data_valid=0, o_full=0, o_rd_en=1, o_tag=0, o_data=0.
  - Reset takes priority over any push or pop in the same cycle; an in-flight packet is lost.
- o_rd_en = !o_full, combinational from the count register. No skid buffer.
- Push when i_pkt_valid && o_rd_en && tag!=0. Tag 0 is the null packet: accepted (consumed), not stored.
- Pop when i_rd_en && o_data_valid. i_rd_en while empty is ignored; pointers and count are unchanged.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- When full, no push is possible that cycle, even if a pop occurs. o_rd_en reasserts the cycle after the pop.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Latency: a packet pushed at edge N appears on o_tag/o_data with o_data_valid=1 after edge N, if the FIFO was empty.
- o_tag/o_data are registered from the head entry. They are 0 when empty and hold the next entry the cycle after a pop.
- Ordering: strict FIFO, no reordering across tags.
- Control is a 3-state occupancy FSM:
  - EMPTY: count=0, o_data_valid=0. Push -> NONEMPTY.
  - NONEMPTY: push-only reaching DEPTH -> FULL; pop-only reaching 0 -> EMPTY.
  - FULL: o_full=1. Pop -> NONEMPTY.

Optional Feature:
- Macro NOC_EJECT_STATS_EN.
- Defined: adds output o_pkt_cnt (16 bits) counting stored packets and o_null_cnt (16 bits) counting consumed tag-0 packets.
  - Both counters saturate at 16'hFFFF and are cleared by i_reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package noc_pkg:
  - constants PACKET_SIZE=16 and HDR_W=4;
  - NULL_TAG=0;
  - functions to extract the tag and payload fields;
  - typedef for the FSM state encoding (EMPTY, NONEMPTY, FULL).
- One sub-module, noc_sync_fifo: storage, pointers, count and full/empty. The top level handles the null filter, field split and optional stats.

Test Plan:
- Reset then idle: after i_reset pulse -> o_rd_en=1, o_data_valid=0, o_full=0, o_tag=0, o_data=0.
- Push 16'h107F, i_rd_en=0 -> next cycle o_data_valid=1, o_tag=4'h1, o_data=12'h07F; holds until i_rd_en=1, then o_data_valid=0.
- Null filter: push 16'h0ABC then 16'h20FE -> only tag 2 / 12'h0FE appears; with NOC_EJECT_STATS_EN, o_null_cnt=1 and o_pkt_cnt=1.
- Fill: 8 pushes 16'h3001..16'h3008, no reads -> o_full=1, o_rd_en=0; a 9th packet is not accepted. Reads return 001..008 in order; o_rd_en returns the cycle after the first pop.
- Simultaneous push/pop at count=3 for 20 cycles -> count stays 3, data order preserved across pointer wrap.
- i_reset asserted with 5 entries stored and a push and pop in the same cycle -> next cycle the FIFO is empty, o_data_valid=0, stats counters=0.
